uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Serial transmitter of the UART pair: it takes a parallel word with a one-cycle valid strobe and emits one asynchronous serial frame on TX_OUT. The frame is a start bit, DATA_WIDTH data bits LSB-first, an optional even/odd parity bit, and one stop bit. The block runs on the TX bit clock, which is already divided down to the baud rate, so each serial bit lasts exactly one CLK cycle. It combines the frame FSM, serializer, parity generator and output mux. Upstream is the TX data synchronizer; downstream is the pad.

## Interface
- DATA_WIDTH, 8, width of the parallel data word (≥2).
- CLK  input  1  TX bit clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word; sampled only on accept.
- DATA_VALID  input  1  one-cycle strobe marking P_DATA valid.
- PAR_EN  input  1  1 = parity bit inserted; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- TX_OUT  output  1  serial line; registered; idles high.
- BUSY  output  1  registered; 1 while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: DATA_VALID=1 while the state is IDLE or STOP.
- On accept:
  - P_DATA, PAR_EN and PAR_TYP are latched into internal registers.
  - Parity is computed from the latched word: even = XOR of all bits; odd = inverted XOR.
  - Later changes on P_DATA, PAR_EN or PAR_TYP do not affect the frame in flight.
- A DATA_VALID asserted in START, DATA or PARITY is ignored and the word is dropped. No error flag is raised; upstream must respect BUSY.
- Transitions:
  - IDLE → START on accept; otherwise stay in IDLE.
  - START → DATA unconditionally after 1 cycle. The bit counter is cleared to 0.
  - DATA: sends latched bit[cnt]. The counter increments each cycle. When cnt = DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else to STOP.
  - PARITY → STOP unconditionally after 1 cycle.
  - STOP → START on accept (back-to-back frame, no idle gap); otherwise → IDLE.
  - Any unused encoding → IDLE.
- TX_OUT per state: IDLE 1, START 0, DATA latched bit[cnt], PARITY parity bit, STOP 1.
- BUSY is 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- Bit counter width is $clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1.

## Timing
- TX_OUT and BUSY are registered from the next-state decode. They change on the same edge as the state, with no combinational path from inputs to outputs.
- Accept at edge k:
  - TX_OUT=0 and BUSY=1 from edge k.
  - Data bit i is on the line during cycle [k+1+i, k+2+i).
  - Parity, if enabled, is on the line during [k+1+DATA_WIDTH, k+2+DATA_WIDTH).
  - The stop bit lasts exactly one cycle.
- Frame length is DATA_WIDTH+2 cycles (10 for the default) without parity, and DATA_WIDTH+3 (11) with parity.
- Without a new accept, BUSY falls and TX_OUT stays 1 on the edge that ends the stop bit.
- Back-to-back: a DATA_VALID during the stop cycle makes the next start bit follow the stop bit directly. BUSY stays 1 throughout and the stop bit is not shortened.
- Reset values, applied immediately on RST=0 in any state:
  - TX_OUT=1, BUSY=0, state IDLE.
  - Bit counter, latched data, latched PAR_EN/PAR_TYP and parity register all 0.
  - A reset mid-frame aborts the frame with the line held high. DATA_VALID during reset is ignored.
- After reset release, the first edge with DATA_VALID=1 is accepted normally.

## Test plan
- No parity, P_DATA=0xA5, one DATA_VALID pulse from IDLE → TX_OUT per cycle is 0,1,0,1,0,0,1,0,1,1. BUSY=1 for exactly 10 cycles, then TX_OUT=1 and BUSY=0.
- PAR_EN=1 with P_DATA=0x07: PAR_TYP=0 → parity bit 1; PAR_TYP=1 → parity bit 0. Then with P_DATA=0xA5, PAR_TYP=0 → parity bit 0. BUSY high for 11 cycles in each frame.
- Back-to-back: 0x55 then 0x0F, the second DATA_VALID in the stop cycle → 20 consecutive bit cycles with no idle gap. BUSY continuously 1. Second frame is 0,1,1,1,1,0,0,0,0,1.
- DATA_VALID with P_DATA=0xFF during the DATA state of a 0x00 frame → 0x00 frame unaltered, 0xFF never transmitted, IDLE reached afterwards.
- PAR_EN, PAR_TYP and P_DATA toggled mid-frame → the frame uses the values latched at accept.
- RST=0 during data bit 3 of a frame → TX_OUT=1 and BUSY=0 asynchronously. After release, line idle. A new 0x3C frame is transmitted correctly.

Source files
------------

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//
// UART serial transmitter. This module contains the frame FSM, the serializer,
// the parity generator and the output mux. It runs on the TX bit clock, so each
// serial bit lasts exactly one CLK cycle.
//
// Frame format:
//   1. start bit (0)
//   2. DATA_WIDTH data bits, LSB first
//   3. optional even/odd parity bit
//   4. one stop bit (1)
//
// Ports:
//   CLK         TX bit clock. All state changes on its rising edge.
//   RST         Asynchronous, active-low reset.
//   P_DATA      Parallel word. Latched on accept.
//   DATA_VALID  One-cycle strobe. It is accepted in IDLE or STOP only.
//   PAR_EN      1 = insert a parity bit. Latched on accept.
//   PAR_TYP     0 = even parity, 1 = odd parity. Latched on accept.
//   TX_OUT      Registered serial line. Idles high.
//   BUSY        Registered. High while a frame is on the line.
// ---------------------------------------------------------------------------
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bit_q;
    logic                  accept;
    logic                  tx_nxt;
    logic                  busy_nxt;

    // A new word is taken only when the line is idle or the stop bit is
    // being sent. A strobe in any other state is dropped silently.
    assign accept = DATA_VALID && ((state == ST_IDLE) || (state == ST_STOP));

    // -----------------------------------------------------------------------
    // Frame FSM and bit counter: next-state decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = ST_IDLE;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                state_nxt = accept ? ST_START : ST_IDLE;
            end
            ST_START: begin
                state_nxt = ST_DATA;
                cnt_nxt   = '0;
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                state_nxt = ST_STOP;
            end
            ST_STOP: begin
                state_nxt = accept ? ST_START : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output mux
    // -----------------------------------------------------------------------
    // This decodes the state and count that will hold after the next edge.
    // Registering the result lets TX_OUT and BUSY change on the same edge as
    // the state, with no combinational path from the inputs to the pins.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            ST_IDLE:   tx_nxt = 1'b1;
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = data_q[cnt_nxt];
            ST_PARITY: tx_nxt = par_bit_q;
            ST_STOP:   tx_nxt = 1'b1;
            default:   tx_nxt = 1'b1;
        endcase
    end

    assign busy_nxt = (state_nxt != ST_IDLE);

    // -----------------------------------------------------------------------
    // State, counter and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            TX_OUT <= tx_nxt;
            BUSY   <= busy_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Word and frame-option latches
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // -----------------------------------------------------------------------
    // Parity generator
    // -----------------------------------------------------------------------
    // Parity is computed from the latched word during the start bit. The word
    // and the parity type are stable by then, and the parity bit is needed
    // only after all data bits have been sent.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_q <= 1'b0;
        end else if (state == ST_START) begin
            par_bit_q <= (^data_q) ^ par_typ_q;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural line model. The model holds a queue of the line levels
    // still to come in the current frame. A frame is the start bit, the data
    // bits LSB first, the optional parity bit and the stop bit. A new word is
    // taken when the line is idle or when the last queued level (the stop bit)
    // is showing.
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;
    logic line_q[$];

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            line_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else if (DATA_VALID && (!exp_busy || line_q.size() == 0)) begin
            line_q.delete();
            for (int i = 0; i < 8; i++) line_q.push_back(P_DATA[i]);
            if (PAR_EN) line_q.push_back((($countones(P_DATA) % 2) == 1) ^ PAR_TYP);
            line_q.push_back(1'b1);
            exp_tx   = 1'b0;
            exp_busy = 1'b1;
        end else if (line_q.size() > 0) begin
            exp_tx   = line_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
    end

    always @(negedge CLK) begin
        check("tx_out_vs_model", {31'd0, TX_OUT}, {31'd0, exp_tx});
        check("busy_vs_model", {31'd0, BUSY}, {31'd0, exp_busy});
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    // Samples n consecutive cycles, starting with the current one. At
    // iteration inj_at it optionally drives new inputs for the next edge.
    task automatic record(input int n, input int inj_at, input logic inj_dv,
                          input logic [7:0] inj_d, input logic inj_pe, input logic inj_pt,
                          output logic [31:0] bits, output int busy_n);
        bits   = '0;
        busy_n = 0;
        for (int i = 0; i < n; i++) begin
            bits[i] = TX_OUT;
            if (BUSY) busy_n++;
            if (i == inj_at) begin
                P_DATA     = inj_d;
                PAR_EN     = inj_pe;
                PAR_TYP    = inj_pt;
                DATA_VALID = inj_dv;
            end
            @(negedge CLK);
            DATA_VALID = 1'b0;
        end
    endtask

    logic [31:0] bits;
    int          busy_n;

    initial begin
        RST        = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Frame 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 then idle.
        send(8'hA5, 1'b0, 1'b0);
        record(12, -1, 1'b0, 8'h00, 1'b0, 1'b0, bits, busy_n);
        check("a5_bits", {20'd0, bits[11:0]}, 32'h0000_0F4A);
        check("a5_busy_len", busy_n, 32'd10);

        // Parity frames.
        send(8'h07, 1'b1, 1'b0);
        record(13, -1, 1'b0, 8'h00, 1'b0, 1'b0, bits, busy_n);
        check("p07_even_bit", {31'd0, bits[9]}, 32'd1);
        check("p07_even_len", busy_n, 32'd11);
        send(8'h07, 1'b1, 1'b1);
        record(13, -1, 1'b0, 8'h00, 1'b0, 1'b0, bits, busy_n);
        check("p07_odd_bit", {31'd0, bits[9]}, 32'd0);
        check("p07_odd_len", busy_n, 32'd11);
        send(8'hA5, 1'b1, 1'b0);
        record(13, -1, 1'b0, 8'h00, 1'b0, 1'b0, bits, busy_n);
        check("pa5_even_bit", {31'd0, bits[9]}, 32'd0);
        check("pa5_even_len", busy_n, 32'd11);

        // Back-to-back: 0x55, then 0x0F accepted during the stop bit.
        send(8'h55, 1'b0, 1'b0);
        record(22, 9, 1'b1, 8'h0F, 1'b0, 1'b0, bits, busy_n);
        check("b2b_first", {22'd0, bits[9:0]}, 32'h0000_02AA);
        check("b2b_second", {22'd0, bits[19:10]}, 32'h0000_021E);
        check("b2b_busy_len", busy_n, 32'd20);
        check("b2b_idle", {30'd0, bits[21:20]}, 32'd3);

        // 0xFF strobed during the data bits of a 0x00 frame is dropped.
        send(8'h00, 1'b0, 1'b0);
        record(12, 3, 1'b1, 8'hFF, 1'b0, 1'b0, bits, busy_n);
        check("drop_bits", {20'd0, bits[11:0]}, 32'h0000_0E00);
        check("drop_busy_len", busy_n, 32'd10);

        // Inputs toggled mid-frame do not alter a 0x5A even-parity frame.
        send(8'h5A, 1'b1, 1'b0);
        record(13, 4, 1'b0, 8'hFF, 1'b0, 1'b1, bits, busy_n);
        check("latch_bits", {19'd0, bits[12:0]}, 32'h0000_1CB4);
        check("latch_busy_len", busy_n, 32'd11);
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;

        // Asynchronous reset during data bit 3.
        send(8'h5A, 1'b0, 1'b0);
        record(4, -1, 1'b0, 8'h00, 1'b0, 1'b0, bits, busy_n);
        #2;
        RST        = 1'b0;
        DATA_VALID = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("async_rst_busy", {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
        RST        = 1'b1;
        DATA_VALID = 1'b0;
        record(3, -1, 1'b0, 8'h00, 1'b0, 1'b0, bits, busy_n);
        check("post_rst_idle", {29'd0, bits[2:0]}, 32'd7);
        check("post_rst_busy", busy_n, 32'd0);
        send(8'h3C, 1'b0, 1'b0);
        record(12, -1, 1'b0, 8'h00, 1'b0, 1'b0, bits, busy_n);
        check("3c_bits", {20'd0, bits[11:0]}, 32'h0000_0E78);
        check("3c_busy_len", busy_n, 32'd10);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
